// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit state encoding.
package uart_mmio_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head, so a consumer can read and pop
// the oldest entry in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // push/pop are single-cycle strobes with no backpressure: a pop on an empty
    // FIFO is ignored, and a push while full only lands if a pop frees the slot
    // in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU-bus console transmitter: byte stores to TXDATA are queued and sent as
// back-to-back 8N1 frames on TxD; STATUS reports FIFO and transmitter state.
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TxD,
    output logic [1:0]  dbg_state
);

    localparam int              TW         = $clog2(CLKS_PER_BIT);
    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overflow;

    logic          hit_txdata;
    logic          hit_status;
    logic          push;
    logic          pop;
    logic          bit_done;
    logic          ovf_set;
    logic          ovf_clr;
    logic          busy;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign hit_txdata = (Address == BASE_ADDR + TXDATA_OFS);
    assign hit_status = (Address == BASE_ADDR + STATUS_OFS);
    assign push       = MemWrite && hit_txdata;
    assign bit_done   = (timer == TIMER_LAST);

    // The head is consumed either when leaving IDLE or at the end of a stop
    // bit, which is what makes queued frames contiguous.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || (state == S_STOP && bit_done));

    assign ovf_set = push && fifo_full && !pop;
    assign ovf_clr = MemWrite && hit_status && WriteData[ST_OVF];
    assign busy    = (state != S_IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status           = '0;
        status[ST_FULL]  = (fifo_count == CW'(FIFO_DEPTH));
        status[ST_EMPTY] = (fifo_count == '0);
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = overflow;
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && hit_status) ReadData = status;
    end

    always_ff @(posedge Clock) begin
        if (Reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TxD     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    TxD     <= 1'b1;
                    if (pop) begin
                        shift <= fifo_head;
                        TxD   <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        timer <= '0;
                        TxD   <= shift[0];
                        state <= S_DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            TxD     <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            TxD     <= shift[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (pop) begin
                            shift <= fifo_head;
                            TxD   <= 1'b0;
                            state <= S_START;
                        end else begin
                            TxD   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
